// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Brief    : Full-width add/subtract sequenced one nibble per cycle through a
//            shared external 4-bit combinational adder, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_cin,
  input  logic                 in_sub,
  output logic [3:0]           adder_a,
  output logic [3:0]           adder_b,
  output logic                 adder_cin,
  input  logic [3:0]           adder_sum,
  input  logic                 adder_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_sum,
  output logic                 out_cout,
  output logic                 out_ovf
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_sum;
  logic              r_carry;
  logic [IDXW-1:0]   r_idx;
  logic              r_cout;
  logic              r_ovf;
  logic              w_last;
  logic              w_accept;
  logic [3:0]        w_a_nib;
  logic [3:0]        w_b_nib;

  assign w_last   = (r_idx == IDXW'(NIBBLES - 1));
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_a_nib  = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_nib  = r_b[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Subtraction is folded into the add path: A + ~B + 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= in_sub ? ~in_b : in_b;
      r_carry <= in_sub ? 1'b1 : in_cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[{r_idx, 2'b00} +: 4] <= adder_sum;
      r_carry                    <= adder_cout;
      if (w_last) begin
        r_cout <= adder_cout;
        r_ovf  <= (r_a[W-1] == r_b[W-1]) && (adder_sum[3] != r_a[W-1]);
      end else begin
        r_idx  <= r_idx + IDXW'(1);
      end
    end
  end

  assign adder_a   = (r_state == RUN) ? w_a_nib : 4'd0;
  assign adder_b   = (r_state == RUN) ? w_b_nib : 4'd0;
  assign adder_cin = (r_state == RUN) ? r_carry : 1'b0;
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Brief    : Directed vectors, handshake corner sequences and random operations
//            checked against a signed/unsigned arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic [3:0]   adder_a;
  logic [3:0]   adder_b;
  logic         adder_cin;
  logic [3:0]   adder_sum;
  logic         adder_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int checks = 0;
  int errors = 0;
  logic [3:0] seen_a [4];

  always #5 clk = ~clk;

  // The shared external 4-bit ripple adder.
  assign {adder_cout, adder_sum} = 5'(adder_a) + 5'(adder_b) + 5'(adder_cin);

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub);
    int sa, sb, sr;
    logic [W:0] u;
    logic c, v;
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      u  = {1'b0, a} - {1'b0, b};
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      u  = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      c  = u[W];
      sr = sa + sb + int'(cin);
    end
    v = (sr > 32767) || (sr < -32768);
    return {v, c, u[W-1:0]};
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input int stall, output logic [W-1:0] sum,
                       output logic cout, output logic ovf, output int lat);
    check("ready_before_issue", in_ready, 1'b1);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (lat < 4) seen_a[lat] = adder_a;
      @(negedge clk);
      lat++;
    end
    sum = out_sum; cout = out_cout; ovf = out_ovf;
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      check("stall_hold", {out_valid, in_ready, out_cout, out_ovf, out_sum},
            {1'b1, 1'b0, cout, ovf, sum});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_to_idle", {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    logic [W-1:0] s;
    logic c, v;
    int lat;
    logic [W+1:0] exp;
    int seen_v;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {in_ready, out_valid, out_cout, out_ovf, out_sum},
          {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    check("reset_adder_drive", {adder_a, adder_b, adder_cin}, 9'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_valid", {in_ready, adder_a, adder_b, adder_cin}, {1'b1, 9'd0});

    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, i % 2, s, c, v, lat);
      check("vec_latency", lat, N);
      check("vec_sum", s, vecs[i].sum);
      check("vec_cout", c, vecs[i].cout);
      check("vec_ovf", v, vecs[i].ovf);
      if (i == 0) check("adder_a_sequence", {seen_a[0], seen_a[1], seen_a[2], seen_a[3]}, 16'h4321);
    end

    // Backpressure, in_valid held throughout, then back-to-back acceptance.
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_a = 16'h0100; in_b = 16'h0200;
    repeat (4) @(negedge clk);
    check("bp_done", {out_valid, in_ready, out_sum}, {1'b1, 1'b0, 16'h3333});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold", {out_valid, in_ready, out_cout, out_ovf, out_sum},
            {1'b1, 1'b0, 1'b0, 1'b0, 16'h3333});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_after_release", {in_ready, out_valid}, 2'b10);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_back_to_back_accept", {in_ready, out_valid}, 2'b00);
    repeat (4) @(negedge clk);
    check("bp_second_result", {out_valid, out_sum}, {1'b1, 16'h0300});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of RUN discards the operation.
    in_a = 16'hABCD; in_b = 16'h1111; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrun_adder_a_idx2", adder_a, 4'hB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_reset_state", {in_ready, out_valid, adder_a, adder_b, adder_cin, out_sum},
          {1'b1, 1'b0, 9'd0, 16'h0000});
    seen_v = 0;
    repeat (10) begin
      @(negedge clk);
      seen_v |= int'(out_valid);
    end
    check("midrun_no_result", seen_v, 0);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, s, c, v, lat);
    check("post_reset_add", {v, c, s}, {1'b0, 1'b0, 16'h0002});

    // Random operations with random idle gaps and output stalls.
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      int gap;
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("rand_idle_drive", {in_ready, adder_a, adder_b, adder_cin}, {1'b1, 9'd0});
      end
      do_op(ra, rb, rc, rs, $urandom_range(0, 3), s, c, v, lat);
      exp = ref_model(ra, rb, rc, rs);
      check("rand_latency", lat, N);
      check("rand_result", {v, c, s}, exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
